// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// a debug read port, and register 0 hardwired to zero. Define REGFILE_BYPASS_EN for write-through reads.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPORT = 3;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic              wr_valid;
  logic [ADDR_W-1:0] rd_addr [NPORT];
  logic [DATA_W-1:0] rd_data [NPORT];

  // A write to entry 0 is never a valid write, so it can neither land nor bypass.
  assign wr_valid = we && !rst && (wa != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_valid) begin
      regs_d[wa] = wd;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_addr[0] = ra1;
  assign rd_addr[1] = ra2;
  assign rd_addr[2] = dbg_addr;

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = regs_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (wa == rd_addr[gi])) begin
          rd_data[gi] = wd;
        end
`endif
      end
    end
  endgenerate

  assign rd1      = rd_data[0];
  assign rd2      = rd_data[1];
  assign dbg_data = rd_data[2];

endmodule
